// File: rtl/draw_objects_pipe_pkg.sv
// Shared graphics constants and types for the pong overlay chain.
package pong_gfx_pkg;

    localparam int BALL_SIZE        = 16;
    localparam int PAD_WIDTH_DEF    = 15;
    localparam int PAD_HEIGHT_DEF   = 145;
    localparam int FLASH_FRAMES_DEF = 30;

    localparam logic [11:0] BALL_RGB_DEF  = 12'hFFF;
    localparam logic [11:0] FLASH_RGB_DEF = 12'hF00;
    localparam logic [11:0] BLANK_RGB     = 12'h000;

    typedef enum logic {IDLE, FLASH} flash_state_t;

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        vblnk;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_pix_t;

endpackage

// File: rtl/draw_objects_pipe_if.sv
// VGA pixel stream bundle: timing counters, syncs, blanks and colour.
interface vga_intf;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in     (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out    (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_objects_pipe_ball_rom.sv
// 16x16 filled-circle bitmap; shared with the score screen.
module ball_rom (
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       pixel
);
    logic [2:0]  half;
    logic [15:0] row_bits;

    // rows 8..15 mirror rows 7..0
    assign half = row[3] ? ~row[2:0] : row[2:0];

    always_comb begin
        case (half)
            3'd0:    row_bits = 16'h0000;
            3'd1:    row_bits = 16'h07E0;
            3'd2:    row_bits = 16'h0FF0;
            3'd3:    row_bits = 16'h1FF8;
            3'd4:    row_bits = 16'h3FFC;
            default: row_bits = 16'h7FFE;
        endcase
    end

    assign pixel = row_bits[col];
endmodule

// File: rtl/draw_objects_pipe.sv
// Ball + pad overlay on the game-field stream, 2-cycle matched pipeline.
//   state | meaning
//   IDLE  | ball drawn in BALL_RGB
//   FLASH | counting frames after a hit; odd flash_cnt draws FLASH_RGB
module draw_objects_pipe
    import pong_gfx_pkg::*;
#(
    parameter int          NUM_PADS     = 2,
    parameter int          PAD_WIDTH    = PAD_WIDTH_DEF,
    parameter int          PAD_HEIGHT   = PAD_HEIGHT_DEF,
    parameter int          FLASH_FRAMES = FLASH_FRAMES_DEF,
    parameter logic [11:0] BALL_RGB     = BALL_RGB_DEF,
    parameter logic [11:0] FLASH_RGB    = FLASH_RGB_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [10:0]              x_ball,
    input  logic [9:0]               y_ball,
    input  logic                     ball_en,
    input  logic                     hit,
    input  logic [NUM_PADS*11-1:0]   x_pad,
    input  logic [NUM_PADS*10-1:0]   y_pad,
    input  logic [NUM_PADS*12-1:0]   pad_rgb,
    vga_intf.in                      game_field_in,
    vga_intf.out                     game_field_out
);
    vga_pix_t            pix_in, pix_s1_d, pix_s1_q, pix_s2_d, pix_s2_q;
    logic                ball_hit_s1_d, ball_hit_s1_q;
    logic                blank_s1_d, blank_s1_q;
    logic [NUM_PADS-1:0] pad_hit_s1_d, pad_hit_s1_q;
    logic [11:0]         hc, vc, xb, yb;
    logic [3:0]          rom_row, rom_col;
    logic                rom_bit, in_box;
    flash_state_t        state_q;
    logic [4:0]          flash_cnt_q;
    logic                vblnk_prev_q, frame_tick;
    logic [11:0]         ball_rgb;

    assign pix_in = {game_field_in.vcount, game_field_in.hcount, game_field_in.vsync,
                     game_field_in.vblnk, game_field_in.hsync, game_field_in.hblnk,
                     game_field_in.rgb};

    // 12-bit compares so x+size never wraps back onto column 0
    assign hc = {1'b0, pix_in.hcount};
    assign vc = {1'b0, pix_in.vcount};
    assign xb = {1'b0, x_ball};
    assign yb = {2'b0, y_ball};
    assign in_box = (hc >= xb) && (hc <= xb + 12'(BALL_SIZE - 1)) &&
                    (vc >= yb) && (vc <= yb + 12'(BALL_SIZE - 1));
    assign rom_row = pix_in.vcount[3:0] - y_ball[3:0];
    assign rom_col = pix_in.hcount[3:0] - x_ball[3:0];

    ball_rom u_ball_rom (.row(rom_row), .col(rom_col), .pixel(rom_bit));

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic [11:0] px, py;
        assign px = {1'b0, x_pad[11*i +: 11]};
        assign py = {2'b0, y_pad[10*i +: 10]};
        assign pad_hit_s1_d[i] = (hc >= px) && (hc <= px + 12'(PAD_WIDTH)) &&
                                 (vc >= py) && (vc <= py + 12'(PAD_HEIGHT));
    end

    assign ball_hit_s1_d = ball_en & in_box & rom_bit;
    assign blank_s1_d    = pix_in.hblnk | pix_in.vblnk;
    assign pix_s1_d      = pix_in;

    assign ball_rgb   = (state_q == FLASH && flash_cnt_q[0]) ? FLASH_RGB : BALL_RGB;
    assign frame_tick = pix_in.vblnk & ~vblnk_prev_q;

    always_comb begin
        pix_s2_d = pix_s1_q;
        if (blank_s1_q) begin
            pix_s2_d.rgb = BLANK_RGB;
        end else if (ball_hit_s1_q) begin
            pix_s2_d.rgb = ball_rgb;
        end else begin
            for (int i = NUM_PADS - 1; i >= 0; i--) begin
                if (pad_hit_s1_q[i]) pix_s2_d.rgb = pad_rgb[12*i +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_s1_q      <= '0;
            ball_hit_s1_q <= 1'b0;
            blank_s1_q    <= 1'b0;
            pad_hit_s1_q  <= '0;
            pix_s2_q      <= '0;
        end else begin
            pix_s1_q      <= pix_s1_d;
            ball_hit_s1_q <= ball_hit_s1_d;
            blank_s1_q    <= blank_s1_d;
            pad_hit_s1_q  <= pad_hit_s1_d;
            pix_s2_q      <= pix_s2_d;
        end
    end

    // a hit outranks a coincident frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            flash_cnt_q  <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            vblnk_prev_q <= pix_in.vblnk;
            if (hit) begin
                state_q     <= FLASH;
                flash_cnt_q <= 5'(FLASH_FRAMES);
            end else if (state_q == FLASH && frame_tick) begin
                if (flash_cnt_q == 5'd1) state_q <= IDLE;
                flash_cnt_q <= flash_cnt_q - 5'd1;
            end
        end
    end

    assign game_field_out.vcount = pix_s2_q.vcount;
    assign game_field_out.hcount = pix_s2_q.hcount;
    assign game_field_out.vsync  = pix_s2_q.vsync;
    assign game_field_out.vblnk  = pix_s2_q.vblnk;
    assign game_field_out.hsync  = pix_s2_q.hsync;
    assign game_field_out.hblnk  = pix_s2_q.hblnk;
    assign game_field_out.rgb    = pix_s2_q.rgb;
endmodule

// File: tb/tb_draw_objects_pipe.sv
// Scoreboard bench for draw_objects_pipe: expected pixels are queued at drive
// time from an integer model and popped when they reach the output.
module tb_draw_objects_pipe;
    import pong_gfx_pkg::*;

    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [10:0]       x_ball;
    logic [9:0]        y_ball;
    logic              ball_en;
    logic              hit;
    logic [NP*11-1:0]  x_pad;
    logic [NP*10-1:0]  y_pad;
    logic [NP*12-1:0]  pad_rgb;

    vga_intf vin();
    vga_intf vout();

    draw_objects_pipe #(.NUM_PADS(NP)) dut (
        .clk            (clk),
        .rst            (rst),
        .x_ball         (x_ball),
        .y_ball         (y_ball),
        .ball_en        (ball_en),
        .hit            (hit),
        .x_pad          (x_pad),
        .y_pad          (y_pad),
        .pad_rgb        (pad_rgb),
        .game_field_in  (vin),
        .game_field_out (vout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [37:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  n_pass  = 0;
    int  n_total = 0;

    bit  m_flash;
    int  m_cnt;
    bit  m_prev_vb;

    function automatic bit rom_model(int r, int c);
        int dx = 2 * c - 15;
        int dy = 2 * r - 15;
        return (dx * dx + dy * dy) <= 196;
    endfunction

    function automatic logic [11:0] exp_rgb(int h, int v, bit hb, bit vb, logic [11:0] rin);
        int xb = int'(x_ball);
        int yb = int'(y_ball);
        if (hb || vb) return 12'h000;
        if (ball_en && h >= xb && h <= xb + 15 && v >= yb && v <= yb + 15 &&
            rom_model(v - yb, h - xb))
            return (m_flash && (m_cnt % 2 == 1)) ? 12'hF00 : 12'hFFF;
        for (int i = 0; i < NP; i++) begin
            int px = int'(x_pad[11*i +: 11]);
            int py = int'(y_pad[10*i +: 10]);
            if (h >= px && h <= px + 15 && v >= py && v <= py + 145)
                return pad_rgb[12*i +: 12];
        end
        return rin;
    endfunction

    function automatic logic [37:0] out_bus();
        return {vout.vcount, vout.hcount, vout.vsync, vout.vblnk,
                vout.hsync, vout.hblnk, vout.rgb};
    endfunction

    // One pixel per clock: drive, queue its expectation, retire the one now at the output.
    task automatic step(input int h, input int v, input bit hb, input bit vb,
                        input logic [11:0] rin, input bit h_it, input string nm);
        sb_t e;
        bit hs, vs, tick;
        logic [37:0] got;
        @(negedge clk);
        hs = 1'($urandom);
        vs = 1'($urandom);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rin;
        hit        = h_it;
        tick       = vb && !m_prev_vb;
        m_prev_vb  = vb;
        if (h_it) begin
            m_flash = 1'b1;
            m_cnt   = 30;
        end else if (m_flash && tick) begin
            if (m_cnt == 1) m_flash = 1'b0;
            m_cnt--;
        end
        e.exp  = {11'(v), 11'(h), vs, vb, hs, hb, exp_rgb(h, v, hb, vb, rin)};
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        hit = 1'b0;
        if (sb.size() > 1) begin
            e   = sb.pop_front();
            got = out_bus();
            n_total++;
            if (got !== e.exp)
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else
                n_pass++;
        end
    endtask

    task automatic do_reset(input string nm);
        sb_t z;
        logic [37:0] got;
        @(negedge clk);
        rst        = 1'b1;
        vin.hcount = 11'd507;
        vin.vcount = 11'd207;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'h0A0;
        @(posedge clk);
        #1;
        got = out_bus();
        n_total++;
        if (got !== 38'h0)
            $display("FAIL %s: got %h expected %h", nm, got, 38'h0);
        else
            n_pass++;
        rst = 1'b0;
        sb.delete();
        z.exp  = 38'h0;
        z.name = {nm, "_s1_flush"};
        sb.push_back(z);
        m_flash   = 1'b0;
        m_cnt     = 0;
        m_prev_vb = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        hit     = 1'b0;
        ball_en = 1'b1;
        x_ball  = 11'd500;
        y_ball  = 10'd200;
        x_pad   = {11'd979, 11'd30};
        y_pad   = {10'd300, 10'd100};
        pad_rgb = {12'hF0F, 12'h00F};
        repeat (3) @(posedge clk);
        do_reset("reset");
    endtask

    task automatic test_pads();
        ball_en = 1'b0;
        step(30, 100, 0, 0, 12'h0A0, 0, "pad0_corner");
        step(45, 245, 0, 0, 12'h0A0, 0, "pad0_far_corner");
        step(46, 245, 0, 0, 12'h0A0, 0, "pad0_right_edge_out");
        step(30, 99, 0, 0, 12'h0A0, 0, "pad0_top_edge_out");
        step(994, 445, 0, 0, 12'h0A0, 0, "pad1_far_corner");
        step(995, 445, 0, 0, 12'h0A0, 0, "pad1_right_edge_out");
    endtask

    task automatic test_ball();
        ball_en = 1'b1;
        x_ball  = 11'd500;
        y_ball  = 10'd200;
        step(507, 207, 0, 0, 12'h0A0, 0, "ball_centre");
        step(500, 200, 0, 0, 12'h0A0, 0, "ball_row0_empty");
        step(501, 215, 0, 0, 12'h0A0, 0, "ball_row15_empty");
        step(515, 207, 0, 0, 12'h0A0, 0, "ball_col15_empty");
        step(514, 207, 0, 0, 12'h0A0, 0, "ball_col14_set");
        ball_en = 1'b0;
        step(507, 207, 0, 0, 12'h0A0, 0, "ball_hidden");
        ball_en = 1'b1;
        x_ball  = 11'd2040;
        step(2047, 207, 0, 0, 12'h0A0, 0, "ball_offscreen_visible");
        step(3, 207, 0, 0, 12'h0A0, 0, "ball_no_wrap");
    endtask

    task automatic test_priority();
        x_ball = 11'd35;
        y_ball = 10'd150;
        step(42, 157, 0, 0, 12'h0A0, 0, "ball_over_pad");
        step(35, 150, 0, 0, 12'h0A0, 0, "pad_under_empty_ball_px");
        x_ball = 11'd500;
        x_pad  = {11'd40, 11'd30};
        y_pad  = {10'd120, 10'd100};
        step(50, 130, 0, 0, 12'h0A0, 0, "pad_overlap_low_idx");
        step(50, 250, 0, 0, 12'h0A0, 0, "pad1_below_pad0");
        x_pad  = {11'd979, 11'd30};
        y_pad  = {10'd300, 10'd100};
    endtask

    task automatic test_blank();
        x_ball = 11'd35;
        y_ball = 10'd150;
        step(42, 157, 1, 0, 12'h0A0, 0, "hblnk_ball");
        step(40, 120, 1, 0, 12'h0A0, 0, "hblnk_pad");
        step(40, 120, 0, 1, 12'h0A0, 0, "vblnk_pad");
        step(40, 120, 0, 0, 12'h0A0, 0, "pad_after_blank");
        x_ball = 11'd500;
        y_ball = 10'd200;
    endtask

    task automatic flash_frame(input bit hit_on_tick, input bit hit_on_px);
        step(0, 0, 0, 1, 12'h0A0, hit_on_tick, "flash_vbl");
        step(507, 207, 0, 0, 12'h0A0, hit_on_px, "flash_ball");
    endtask

    task automatic test_flash();
        x_ball  = 11'd500;
        y_ball  = 10'd200;
        ball_en = 1'b1;
        step(507, 207, 0, 0, 12'h0A0, 1, "flash_hit_cnt30");
        for (int f = 0; f < 9; f++) flash_frame(0, 0);
        flash_frame(0, 1);
        step(507, 207, 0, 0, 12'h0A0, 0, "flash_restarted");
        flash_frame(0, 0);
        flash_frame(1, 0);
        for (int f = 0; f < 31; f++) flash_frame(0, 0);
    endtask

    task automatic test_reset_midflash();
        step(507, 207, 0, 0, 12'h0A0, 1, "pre_rst_hit");
        flash_frame(0, 0);
        step(507, 207, 0, 0, 12'h0A0, 0, "pre_rst_flash");
        do_reset("reset_midflash");
        step(507, 207, 0, 0, 12'h0A0, 0, "post_rst_ball_idle");
        step(30, 100, 0, 0, 12'h0A0, 0, "post_rst_pad");
        flash_frame(0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++)
            step(int'($urandom_range(0, 1100)), int'($urandom_range(0, 500)),
                 1'($urandom_range(0, 7) == 0), 1'b0, 12'($urandom), 0, "random_px");
        step(0, 0, 1, 1, 12'h000, 0, "drain0");
        step(0, 0, 1, 1, 12'h000, 0, "drain1");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = '0;
        test_reset();
        test_pads();
        test_ball();
        test_priority();
        test_blank();
        test_flash();
        test_reset_midflash();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
